// File: rtl/bp_update_scheduler_if.sv
// bp_update_scheduler_if: resolved-branch update stream in, branch-buffer write port and status out
interface bp_update_scheduler_if #(
   parameter int INDEX_W = 8,
   parameter int TAG_W = 22
);
   logic upd_valid;
   logic [31:0] upd_pc;
   logic upd_taken;
   logic [31:0] upd_target;
   logic [1:0] upd_type;
   logic flush_req;
   logic stall;
   logic bb_we;
   logic [INDEX_W-1:0] bb_index;
   logic [TAG_W-1:0] bb_tag;
   logic bb_valid;
   logic bb_taken;
   logic [31:0] bb_target;
   logic [1:0] bb_type;
   logic busy;
   logic fifo_full;
   logic [15:0] drop_cnt;
   modport master (
      output upd_valid, upd_pc, upd_taken, upd_target, upd_type, flush_req, stall,
      input bb_we, bb_index, bb_tag, bb_valid, bb_taken, bb_target, bb_type, busy, fifo_full, drop_cnt
   );
   modport slave (
      input upd_valid, upd_pc, upd_taken, upd_target, upd_type, flush_req, stall,
      output bb_we, bb_index, bb_tag, bb_valid, bb_taken, bb_target, bb_type, busy, fifo_full, drop_cnt
   );
endinterface

// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler: queues resolved branches and sequences invalidation sweeps and updates into the branch buffer
module bp_update_scheduler #(
   parameter int FIFO_DEPTH = 4,
   parameter int INDEX_W = 8,
   parameter int TAG_W = 22
) (
   input logic clk,
   input logic reset,
   bp_update_scheduler_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int RW = 65;
   typedef enum logic {SWEEP, DRAIN} state_t;
   state_t state, state_n;
   logic [INDEX_W-1:0] sweep_idx, sweep_idx_n, sw_idx;
   logic [AW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
   logic [RW-1:0] mem [FIFO_DEPTH];
   logic [RW-1:0] head;
   logic empty, full, full_n, sw_act, pop, push, drop, unused_pc_lsb;
   logic bb_we_n, bb_valid_n, bb_taken_n;
   logic [INDEX_W-1:0] bb_index_n;
   logic [TAG_W-1:0] bb_tag_n;
   logic [31:0] bb_target_n;
   logic [1:0] bb_type_n;
   // record layout: {pc[31:2], taken, target, type}
   assign head = mem[rd_ptr[AW-1:0]];
   assign empty = wr_ptr == rd_ptr;
   assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // a flush behaves as if the sweep were already at index 0 this cycle
   assign sw_act = bus.flush_req || state == SWEEP;
   assign sw_idx = bus.flush_req ? '0 : sweep_idx;
   assign pop = !sw_act && !empty && !bus.stall;
   assign push = bus.upd_valid && !bus.flush_req && (!full || pop);
   assign drop = bus.upd_valid && !bus.flush_req && full && !pop;
   assign wr_ptr_n = bus.flush_req ? '0 : wr_ptr + PW'(push);
   assign rd_ptr_n = bus.flush_req ? '0 : rd_ptr + PW'(pop);
   assign full_n = (wr_ptr_n[AW] != rd_ptr_n[AW]) && (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
   assign unused_pc_lsb = ^bus.upd_pc[1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SWEEP;
         sweep_idx <= '0;
      end else begin
         state <= state_n;
         sweep_idx <= sweep_idx_n;
      end
   end

   always_comb begin
      state_n = (sw_act && !(&sw_idx)) ? SWEEP : DRAIN;
      sweep_idx_n = sw_act ? sw_idx + INDEX_W'(1) : sweep_idx;
   end

   always_comb begin
      bb_we_n = sw_act || pop;
      bb_valid_n = sw_act ? 1'b0 : (pop || bus.bb_valid);
      bb_index_n = sw_act ? sw_idx : pop ? head[INDEX_W+34:35] : bus.bb_index;
      bb_tag_n = sw_act ? '0 : pop ? head[64:INDEX_W+35] : bus.bb_tag;
      bb_taken_n = sw_act ? 1'b0 : pop ? head[34] : bus.bb_taken;
      bb_target_n = sw_act ? '0 : pop ? head[33:2] : bus.bb_target;
      bb_type_n = sw_act ? '0 : pop ? head[1:0] : bus.bb_type;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         bus.bb_we <= 1'b0;
         bus.bb_valid <= 1'b0;
         bus.bb_index <= '0;
         bus.bb_tag <= '0;
         bus.bb_taken <= 1'b0;
         bus.bb_target <= '0;
         bus.bb_type <= '0;
         bus.busy <= 1'b1;
         bus.fifo_full <= 1'b0;
         bus.drop_cnt <= '0;
      end else begin
         wr_ptr <= wr_ptr_n;
         rd_ptr <= rd_ptr_n;
         bus.bb_we <= bb_we_n;
         bus.bb_valid <= bb_valid_n;
         bus.bb_index <= bb_index_n;
         bus.bb_tag <= bb_tag_n;
         bus.bb_taken <= bb_taken_n;
         bus.bb_target <= bb_target_n;
         bus.bb_type <= bb_type_n;
         bus.busy <= sw_act;
         bus.fifo_full <= full_n;
         if (drop && !(&bus.drop_cnt)) bus.drop_cnt <= bus.drop_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {bus.upd_pc[31:2], bus.upd_taken, bus.upd_target, bus.upd_type};
   end
endmodule

// File: tb/tb_bp_update_scheduler.sv
// tb_bp_update_scheduler: randomized scenarios checked against a queue-based model of the scheduler
module tb_bp_update_scheduler;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int tests_run = 0;
   int tests_failed = 0;

   bp_update_scheduler_if #(.INDEX_W(8), .TAG_W(22)) bus ();
   bp_update_scheduler #(.FIFO_DEPTH(4), .INDEX_W(8), .TAG_W(22)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic taken;
      logic [31:0] target;
      logic [1:0] typ;
   } rec_t;

   rec_t q[$];
   int m_sweep;
   int m_drop;
   logic m_we, m_valid, m_taken, m_busy, m_full;
   logic [7:0] m_index;
   logic [21:0] m_tag;
   logic [31:0] m_target;
   logic [1:0] m_type;

   // model: the queue holds accepted records; m_sweep is the next index to invalidate, -1 when idle
   task automatic model_step();
      rec_t r;
      if (reset) begin
         q.delete();
         m_sweep = 0;
         {m_we, m_valid, m_index, m_tag, m_taken, m_target, m_type} = '0;
         m_busy = 1'b1;
         m_full = 1'b0;
         m_drop = 0;
         return;
      end
      if (bus.flush_req) begin
         q.delete();
         m_sweep = 0;
      end
      if (m_sweep >= 0) begin
         {m_valid, m_tag, m_taken, m_target, m_type} = '0;
         m_we = 1'b1;
         m_index = 8'(m_sweep);
         m_busy = 1'b1;
         m_sweep = (m_sweep == 255) ? -1 : m_sweep + 1;
      end else if (q.size() > 0 && !bus.stall) begin
         r = q.pop_front();
         m_we = 1'b1;
         m_valid = 1'b1;
         m_index = r.pc[9:2];
         m_tag = r.pc[31:10];
         m_taken = r.taken;
         m_target = r.target;
         m_type = r.typ;
         m_busy = 1'b0;
      end else begin
         m_we = 1'b0;
         m_busy = 1'b0;
      end
      if (bus.upd_valid && !bus.flush_req) begin
         if (q.size() < 4) q.push_back({bus.upd_pc, bus.upd_taken, bus.upd_target, bus.upd_type});
         else if (m_drop < 65535) m_drop++;
      end
      m_full = q.size() == 4;
   endtask

   function automatic logic [84:0] obs();
      return {bus.bb_we, bus.bb_valid, bus.bb_index, bus.bb_tag, bus.bb_taken, bus.bb_target,
              bus.bb_type, bus.busy, bus.fifo_full, bus.drop_cnt};
   endfunction

   function automatic logic [84:0] exp_v();
      return {m_we, m_valid, m_index, m_tag, m_taken, m_target, m_type, m_busy, m_full, 16'(m_drop)};
   endfunction

   function automatic rec_t rnd_rec();
      rec_t r;
      r.pc = $urandom;
      r.taken = 1'($urandom);
      r.target = $urandom;
      r.typ = 2'($urandom);
      return r;
   endfunction

   task automatic drive(input logic v, input rec_t r, input logic fl, input logic st);
      bus.upd_valid = v;
      bus.upd_pc = r.pc;
      bus.upd_taken = r.taken;
      bus.upd_target = r.target;
      bus.upd_type = r.typ;
      bus.flush_req = fl;
      bus.stall = st;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0);
      repeat (3) tick();
      tests_run++;
      if (obs() !== exp_v()) begin
         tests_failed++;
         $display("FAIL reset_model got=%h exp=%h", obs(), exp_v());
      end
      tests_run++;
      if ({bus.busy, bus.bb_we, bus.bb_index, bus.fifo_full, bus.drop_cnt} !== {1'b1, 1'b0, 8'h0, 1'b0, 16'h0}) begin
         tests_failed++;
         $display("FAIL reset_values busy=%b we=%b idx=%h full=%b drop=%h", bus.busy, bus.bb_we, bus.bb_index, bus.fifo_full, bus.drop_cnt);
      end
   endtask

   task automatic test_sweep();
      reset = 1'b0;
      for (int i = 0; i < 256; i++) begin
         tick();
         tests_run++;
         if (obs() !== exp_v() || bus.bb_we !== 1'b1 || bus.bb_valid !== 1'b0 || bus.bb_index !== 8'(i) || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL sweep cyc=%0d got=%h exp=%h", i, obs(), exp_v());
         end
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         tests_run++;
         if (obs() !== exp_v() || bus.busy !== 1'b0 || bus.bb_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL sweep_end cyc=%0d busy=%b we=%b exp_busy=0 exp_we=0", i, bus.busy, bus.bb_we);
         end
      end
   endtask

   task automatic test_single();
      rec_t r;
      r = '{pc: 32'h8000_1234, taken: 1'b1, target: 32'h8000_2000, typ: 2'd2};
      drive(1'b1, r, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      tests_run++;
      if (bus.bb_we !== 1'b0 || obs() !== exp_v()) begin
         tests_failed++;
         $display("FAIL single_lat1 we=%b exp=0", bus.bb_we);
      end
      tick();
      tests_run++;
      if ({bus.bb_we, bus.bb_valid, bus.bb_index, bus.bb_tag, bus.bb_taken, bus.bb_target, bus.bb_type} !==
          {1'b1, 1'b1, 8'h8D, 22'h200004, 1'b1, 32'h8000_2000, 2'd2} || obs() !== exp_v()) begin
         tests_failed++;
         $display("FAIL single_write got=%h exp=%h", obs(), exp_v());
      end
      tick();
      tests_run++;
      if (bus.bb_we !== 1'b0 || obs() !== exp_v()) begin
         tests_failed++;
         $display("FAIL single_once we=%b exp=0", bus.bb_we);
      end
   endtask

   task automatic test_overflow();
      rec_t sent[6];
      for (int i = 0; i < 6; i++) begin
         sent[i] = rnd_rec();
         drive(1'b1, sent[i], 1'b0, 1'b1);
         tick();
         tests_run++;
         if (obs() !== exp_v() || bus.bb_we !== 1'b0 || bus.fifo_full !== (i >= 3)) begin
            tests_failed++;
            $display("FAIL overflow_push i=%0d full=%b got=%h exp=%h", i, bus.fifo_full, obs(), exp_v());
         end
      end
      tests_run++;
      if (bus.drop_cnt !== 16'd2) begin
         tests_failed++;
         $display("FAIL overflow_drops got=%0d exp=2", bus.drop_cnt);
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         tests_run++;
         if (obs() !== exp_v() || bus.bb_we !== 1'b1 || bus.bb_target !== sent[i].target || bus.bb_index !== sent[i].pc[9:2]) begin
            tests_failed++;
            $display("FAIL overflow_drain i=%0d got=%h exp=%h", i, obs(), exp_v());
         end
      end
      tick();
      tests_run++;
      if (obs() !== exp_v() || bus.bb_we !== 1'b0 || bus.fifo_full !== 1'b0) begin
         tests_failed++;
         $display("FAIL overflow_empty we=%b full=%b exp 0 0", bus.bb_we, bus.fifo_full);
      end
   endtask

   task automatic test_flush_queue();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, rnd_rec(), 1'b0, 1'b1);
         tick();
      end
      drive(1'b1, rnd_rec(), 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      tests_run++;
      if (obs() !== exp_v() || {bus.bb_we, bus.bb_valid, bus.bb_index, bus.busy} !== {1'b1, 1'b0, 8'h0, 1'b1}) begin
         tests_failed++;
         $display("FAIL flushq_first got=%h exp=%h", obs(), exp_v());
      end
      for (int i = 1; i < 256; i++) begin
         tick();
         tests_run++;
         if (obs() !== exp_v() || bus.bb_valid !== 1'b0 || bus.bb_index !== 8'(i)) begin
            tests_failed++;
            $display("FAIL flushq_sweep i=%0d got=%h exp=%h", i, obs(), exp_v());
         end
      end
      repeat (2) begin
         tick();
         tests_run++;
         if (obs() !== exp_v() || bus.bb_we !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL flushq_discard we=%b busy=%b exp 0 0", bus.bb_we, bus.busy);
         end
      end
   endtask

   task automatic test_flush_midsweep();
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      repeat (100) tick();
      tests_run++;
      if (obs() !== exp_v() || bus.bb_index !== 8'd100) begin
         tests_failed++;
         $display("FAIL midsweep_at100 idx=%0d exp=100", bus.bb_index);
      end
      drive(1'b0, '0, 1'b1, 1'b1);
      tick();
      drive(1'b0, '0, 1'b0, 1'b1);
      tests_run++;
      if (obs() !== exp_v() || {bus.bb_we, bus.bb_index, bus.busy} !== {1'b1, 8'h0, 1'b1}) begin
         tests_failed++;
         $display("FAIL midsweep_restart got=%h exp=%h", obs(), exp_v());
      end
      for (int i = 1; i < 256; i++) begin
         tick();
         tests_run++;
         if (obs() !== exp_v() || bus.busy !== 1'b1 || bus.bb_index !== 8'(i)) begin
            tests_failed++;
            $display("FAIL midsweep_busy i=%0d busy=%b idx=%0d", i, bus.busy, bus.bb_index);
         end
      end
      tick();
      tests_run++;
      if (obs() !== exp_v() || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL midsweep_fall busy=%b exp=0", bus.busy);
      end
   endtask

   task automatic test_full_stream();
      drive(1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, rnd_rec(), 1'b0, 1'b1);
         tick();
      end
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, rnd_rec(), 1'b0, 1'b0);
         tick();
         tests_run++;
         if (obs() !== exp_v() || bus.fifo_full !== 1'b1 || bus.bb_we !== 1'b1 || bus.drop_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL full_stream i=%0d got=%h exp=%h", i, obs(), exp_v());
         end
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      repeat (5) begin
         tick();
         tests_run++;
         if (obs() !== exp_v()) begin
            tests_failed++;
            $display("FAIL full_drain got=%h exp=%h", obs(), exp_v());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(3, 0) != 0), rnd_rec(), 1'($urandom_range(99, 0) == 0), 1'($urandom_range(2, 0) == 0));
         tick();
         tests_run++;
         if (obs() !== exp_v()) begin
            tests_failed++;
            $display("FAIL random i=%0d got=%h exp=%h", i, obs(), exp_v());
         end
      end
   endtask

   task automatic test_saturate();
      drive(1'b1, rnd_rec(), 1'b0, 1'b1);
      repeat (65544) tick();
      tests_run++;
      if (obs() !== exp_v() || bus.drop_cnt !== 16'hFFFF) begin
         tests_failed++;
         $display("FAIL saturate drop=%h exp=ffff", bus.drop_cnt);
      end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      tick();
      tests_run++;
      if (obs() !== exp_v() || {bus.drop_cnt, bus.fifo_full, bus.busy, bus.bb_we} !== {16'h0, 1'b0, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_mid got=%h exp=%h", obs(), exp_v());
      end
      reset = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0);
      tick();
      tests_run++;
      if (obs() !== exp_v() || {bus.bb_we, bus.bb_index, bus.bb_valid} !== {1'b1, 8'h0, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_mid_sweep got=%h exp=%h", obs(), exp_v());
      end
   endtask

   initial begin
      drive(1'b0, '0, 1'b0, 1'b0);
      test_reset();
      test_sweep();
      test_single();
      test_overflow();
      test_flush_queue();
      test_flush_midsweep();
      test_full_stream();
      test_random();
      test_saturate();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
